uart_rx_cfg: RTL and testbench

Runtime-configurable UART receiver; successor to the fixed 8N1 receiver. Supports 5–8 data bits, optional even/odd parity, 1 or 2 stop bits, a DIV_W-bit baud divider, and 3-sample majority voting per bit. Reports framing, parity and break conditions alongside each received character. Sits between the board RX pin and the per-core MMIO UART/token logic.

---
 rtl/uart_rx_cfg.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: 5-8 data bits, optional even/odd parity, 1 or 2 stop bits,
// 3-sample majority vote per bit, with parity, framing and break status reported per character.
module uart_rx_cfg #(
  parameter int DIV_W = 16
) (
  input  logic             i_Clock,
  input  logic             i_Rst_n,
  input  logic [DIV_W-1:0] i_Clks_Per_Bit,
  input  logic [1:0]       i_Data_Bits,
  input  logic             i_Parity_En,
  input  logic             i_Parity_Odd,
  input  logic             i_Two_Stop,
  input  logic             i_Rx_Serial,
  output logic             o_Rx_DV,
  output logic [7:0]       o_Rx_Byte,
  output logic             o_Parity_Err,
  output logic             o_Frame_Err,
  output logic             o_Break
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t           state, state_nxt;
  logic             rx_meta, rx_s;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] clks_q;
  logic [1:0]       bits_q;
  logic             par_en_q, par_odd_q, two_stop_q;
  logic [2:0]       bit_idx;
  logic             stop_idx;
  logic [7:0]       data_q;
  logic             s_early, s_mid;
  logic             par_err_q, frm_err_q, all_zero_q;

  logic [DIV_W-1:0] m_val;
  logic [2:0]       last_idx;
  logic             vote, at_vote, cnt_last, start_det, final_stop, done, in_frame;

  always_comb begin
    m_val      = (clks_q - ONE) >> 1;
    last_idx   = 3'd4 + {1'b0, bits_q};
    at_vote    = (cnt == m_val + ONE);
    cnt_last   = (cnt == clks_q - ONE);
    // Third sample is the live synchronized line at count M+1.
    vote       = (s_early & s_mid) | (s_early & rx_s) | (s_mid & rx_s);
    start_det  = (state == S_IDLE) && !rx_s;
    final_stop = !two_stop_q || stop_idx;
    done       = (state == S_STOP) && at_vote && final_stop;
    in_frame   = (state == S_START) || (state == S_DATA) ||
                 (state == S_PARITY) || (state == S_STOP);
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      S_IDLE:   if (!rx_s) state_nxt = S_START;
      S_START: begin
        if (at_vote && vote) state_nxt = S_IDLE;
        else if (cnt_last)   state_nxt = S_DATA;
      end
      S_DATA: begin
        if (cnt_last && bit_idx == last_idx)
          state_nxt = par_en_q ? S_PARITY : S_STOP;
      end
      S_PARITY: if (cnt_last) state_nxt = S_STOP;
      S_STOP: begin
        // Leave on the final stop vote, half a bit early, so the next start edge is not missed.
        if (at_vote && final_stop) state_nxt = vote ? S_IDLE : S_WAIT_HIGH;
      end
      S_WAIT_HIGH: if (rx_s) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      // Synchronizer resets to the idle line level so reset release is not seen as a start bit.
      rx_meta      <= 1'b1;
      rx_s         <= 1'b1;
      cnt          <= '0;
      clks_q       <= '0;
      bits_q       <= '0;
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      two_stop_q   <= 1'b0;
      bit_idx      <= '0;
      stop_idx     <= 1'b0;
      data_q       <= '0;
      s_early      <= 1'b0;
      s_mid        <= 1'b0;
      par_err_q    <= 1'b0;
      frm_err_q    <= 1'b0;
      all_zero_q   <= 1'b0;
      o_Rx_DV      <= 1'b0;
      o_Rx_Byte    <= '0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Break      <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every register sees pre-edge values.
      rx_meta <= i_Rx_Serial;
      rx_s    <= rx_meta;
      o_Rx_DV <= 1'b0;

      if (start_det) begin
        clks_q     <= i_Clks_Per_Bit;
        bits_q     <= i_Data_Bits;
        par_en_q   <= i_Parity_En;
        par_odd_q  <= i_Parity_Odd;
        two_stop_q <= i_Two_Stop;
        cnt        <= ONE;
        bit_idx    <= '0;
        stop_idx   <= 1'b0;
        data_q     <= '0;
        par_err_q  <= 1'b0;
        frm_err_q  <= 1'b0;
        all_zero_q <= 1'b1;
        // The detection cycle is count 0; it stands in as the early sample when M-1 is 0.
        s_early    <= rx_s;
      end else if (in_frame) begin
        cnt <= cnt_last ? '0 : cnt + ONE;
        if (cnt == m_val - ONE) s_early <= rx_s;
        if (cnt == m_val)       s_mid   <= rx_s;

        if (at_vote) begin
          if (state != S_START && vote) all_zero_q <= 1'b0;
          case (state)
            S_DATA:   data_q[bit_idx] <= vote;
            S_PARITY: if (vote != ((^data_q) ^ par_odd_q)) par_err_q <= 1'b1;
            S_STOP:   if (!vote) frm_err_q <= 1'b1;
            default:  ;
          endcase
        end

        if (cnt_last && state == S_DATA) bit_idx  <= bit_idx + 3'd1;
        if (cnt_last && state == S_STOP) stop_idx <= 1'b1;

        if (done) begin
          o_Rx_DV      <= 1'b1;
          o_Rx_Byte    <= data_q;
          o_Parity_Err <= par_en_q & par_err_q;
          o_Frame_Err  <= frm_err_q | ~vote;
          o_Break      <= all_zero_q & ~vote;
        end

        if (state_nxt == S_IDLE || state_nxt == S_WAIT_HIGH) cnt <= '0;
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: serial frames driven on falling clock edges, DV captured by a monitor.
module tb_uart_rx_cfg;

  localparam int DIV_W = 16;

  logic             i_Clock = 1'b0;
  logic             i_Rst_n;
  logic [DIV_W-1:0] i_Clks_Per_Bit;
  logic [1:0]       i_Data_Bits;
  logic             i_Parity_En;
  logic             i_Parity_Odd;
  logic             i_Two_Stop;
  logic             i_Rx_Serial;
  logic             o_Rx_DV;
  logic [7:0]       o_Rx_Byte;
  logic             o_Parity_Err;
  logic             o_Frame_Err;
  logic             o_Break;

  uart_rx_cfg #(.DIV_W(DIV_W)) dut (
    .i_Clock       (i_Clock),
    .i_Rst_n       (i_Rst_n),
    .i_Clks_Per_Bit(i_Clks_Per_Bit),
    .i_Data_Bits   (i_Data_Bits),
    .i_Parity_En   (i_Parity_En),
    .i_Parity_Odd  (i_Parity_Odd),
    .i_Two_Stop    (i_Two_Stop),
    .i_Rx_Serial   (i_Rx_Serial),
    .o_Rx_DV       (o_Rx_DV),
    .o_Rx_Byte     (o_Rx_Byte),
    .o_Parity_Err  (o_Parity_Err),
    .o_Frame_Err   (o_Frame_Err),
    .o_Break       (o_Break)
  );

  always #5 i_Clock = ~i_Clock;

  int cyc = 0;
  always @(posedge i_Clock) cyc++;

  int         dv_count = 0;
  int         dv_cyc   = 0;
  logic [7:0] cap_byte = '0;
  logic       cap_par  = 1'b0;
  logic       cap_frm  = 1'b0;
  logic       cap_brk  = 1'b0;

  always @(negedge i_Clock) begin
    if (o_Rx_DV === 1'b1) begin
      dv_count++;
      dv_cyc   = cyc;
      cap_byte = o_Rx_Byte;
      cap_par  = o_Parity_Err;
      cap_frm  = o_Frame_Err;
      cap_brk  = o_Break;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int c, input logic [1:0] db, input logic pe, input logic po,
                         input logic ts);
    i_Clks_Per_Bit = DIV_W'(c);
    i_Data_Bits    = db;
    i_Parity_En    = pe;
    i_Parity_Odd   = po;
    i_Two_Stop     = ts;
  endtask

  // One bit period; with glitch set, the line is inverted for the single cycle seen at count M.
  task automatic send_bit(input logic b, input int c, input bit glitch);
    int m;
    m = (c - 1) / 2;
    i_Rx_Serial = b;
    if (!glitch) begin
      repeat (c) @(negedge i_Clock);
    end else begin
      repeat (m) @(negedge i_Clock);
      i_Rx_Serial = ~b;
      @(negedge i_Clock);
      i_Rx_Serial = b;
      repeat (c - m - 1) @(negedge i_Clock);
    end
  endtask

  // par < 0 means no parity bit; otherwise par[0] is the parity bit driven on the line.
  task automatic send_frame(input logic [7:0] d, input int n, input int par, input logic stop_v,
                            input int nstop, input int c, input int glitch_idx);
    send_bit(1'b0, c, 1'b0);
    for (int i = 0; i < n; i++) send_bit(d[i], c, i == glitch_idx);
    if (par >= 0) send_bit(par[0], c, 1'b0);
    for (int i = 0; i < nstop; i++) send_bit(stop_v, c, 1'b0);
    i_Rx_Serial = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_Clock);
  endtask

  int t0;

  initial begin
    i_Rst_n     = 1'b0;
    i_Rx_Serial = 1'b1;
    set_cfg(16, 2'b11, 1'b0, 1'b0, 1'b0);
    idle(3);
    check("rst_dv",   32'(o_Rx_DV),      32'h0);
    check("rst_byte", 32'(o_Rx_Byte),    32'h0);
    check("rst_par",  32'(o_Parity_Err), 32'h0);
    check("rst_frm",  32'(o_Frame_Err),  32'h0);
    check("rst_brk",  32'(o_Break),      32'h0);
    i_Rst_n = 1'b1;
    idle(5);

    // 8N1, C=16, 0xA5: DV 2 + 16*9 + 7 + 2 = 155 cycles after the start edge.
    t0 = cyc;
    send_frame(8'hA5, 8, -1, 1'b1, 1, 16, -1);
    idle(10);
    check("8n1_dv_count", 32'(dv_count), 32'd1);
    check("8n1_byte",     32'(cap_byte), 32'hA5);
    check("8n1_par",      32'(cap_par),  32'h0);
    check("8n1_frm",      32'(cap_frm),  32'h0);
    check("8n1_brk",      32'(cap_brk),  32'h0);
    check("8n1_latency",  32'(dv_cyc - t0), 32'd155);

    // 7E2, C=10, 0x41 has two ones: even parity bit 0 is correct, 1 is an error.
    set_cfg(10, 2'b10, 1'b1, 1'b0, 1'b1);
    send_frame(8'h41, 7, 0, 1'b1, 2, 10, -1);
    idle(10);
    check("7e2_ok_dv_count", 32'(dv_count), 32'd2);
    check("7e2_ok_byte",     32'(cap_byte), 32'h41);
    check("7e2_ok_par",      32'(cap_par),  32'h0);
    check("7e2_ok_frm",      32'(cap_frm),  32'h0);
    send_frame(8'h41, 7, 1, 1'b1, 2, 10, -1);
    idle(10);
    check("7e2_bad_dv_count", 32'(dv_count), 32'd3);
    check("7e2_bad_byte",     32'(cap_byte), 32'h41);
    check("7e2_bad_par",      32'(cap_par),  32'h1);
    check("7e2_bad_frm",      32'(cap_frm),  32'h0);
    check("7e2_bad_brk",      32'(cap_brk),  32'h0);

    // 5O1, C=20, 0x1F (five ones, odd parity bit 0) with a low stop bit, line left low.
    set_cfg(20, 2'b00, 1'b1, 1'b1, 1'b0);
    send_frame(8'h1F, 5, 0, 1'b0, 1, 20, -1);
    i_Rx_Serial = 1'b0;
    idle(10);
    check("5o1_frm_dv_count", 32'(dv_count), 32'd4);
    check("5o1_frm_byte",     32'(cap_byte), 32'h1F);
    check("5o1_frm_par",      32'(cap_par),  32'h0);
    check("5o1_frm_frm",      32'(cap_frm),  32'h1);
    check("5o1_frm_brk",      32'(cap_brk),  32'h0);
    idle(200);
    check("5o1_wait_high_no_dv", 32'(dv_count), 32'd4);
    i_Rx_Serial = 1'b1;
    idle(20);
    // 0x0A has two ones, so the odd parity bit is 1.
    send_frame(8'h0A, 5, 1, 1'b1, 1, 20, -1);
    idle(10);
    check("5o1_next_dv_count", 32'(dv_count), 32'd5);
    check("5o1_next_byte",     32'(cap_byte), 32'h0A);
    check("5o1_next_par",      32'(cap_par),  32'h0);
    check("5o1_next_frm",      32'(cap_frm),  32'h0);

    // Break: line low for three 8N1 frame times at C=16.
    set_cfg(16, 2'b11, 1'b0, 1'b0, 1'b0);
    i_Rx_Serial = 1'b0;
    idle(480);
    check("brk_dv_count", 32'(dv_count), 32'd6);
    check("brk_byte",     32'(cap_byte), 32'h00);
    check("brk_brk",      32'(cap_brk),  32'h1);
    check("brk_frm",      32'(cap_frm),  32'h1);
    check("brk_par",      32'(cap_par),  32'h0);
    i_Rx_Serial = 1'b1;
    idle(40);
    check("brk_release_no_dv", 32'(dv_count), 32'd6);
    send_frame(8'h5A, 8, -1, 1'b1, 1, 16, -1);
    idle(10);
    check("brk_next_dv_count", 32'(dv_count), 32'd7);
    check("brk_next_byte",     32'(cap_byte), 32'h5A);
    check("brk_next_brk",      32'(cap_brk),  32'h0);
    check("brk_next_frm",      32'(cap_frm),  32'h0);

    // 3-cycle start glitch, then a 1-cycle glitch at count M inside data bit 2 of 0x96.
    i_Rx_Serial = 1'b0;
    idle(3);
    i_Rx_Serial = 1'b1;
    idle(40);
    check("glitch_start_no_dv", 32'(dv_count), 32'd7);
    send_frame(8'h96, 8, -1, 1'b1, 1, 16, 2);
    idle(10);
    check("glitch_data_dv_count", 32'(dv_count), 32'd8);
    check("glitch_data_byte",     32'(cap_byte), 32'h96);
    check("glitch_data_frm",      32'(cap_frm),  32'h0);

    // Reset in the middle of the data bits of 0x3C (start, bits 0..3 sent).
    send_bit(1'b0, 16, 1'b0);
    send_bit(1'b0, 16, 1'b0);
    send_bit(1'b0, 16, 1'b0);
    send_bit(1'b1, 16, 1'b0);
    send_bit(1'b1, 16, 1'b0);
    i_Rst_n = 1'b0;
    idle(1);
    check("midrst_dv",   32'(o_Rx_DV),      32'h0);
    check("midrst_byte", 32'(o_Rx_Byte),    32'h0);
    check("midrst_par",  32'(o_Parity_Err), 32'h0);
    check("midrst_frm",  32'(o_Frame_Err),  32'h0);
    check("midrst_brk",  32'(o_Break),      32'h0);
    i_Rx_Serial = 1'b1;
    idle(5);
    i_Rst_n = 1'b1;
    idle(200);
    check("midrst_no_dv", 32'(dv_count), 32'd8);
    send_frame(8'h3C, 8, -1, 1'b1, 1, 16, -1);
    idle(10);
    check("after_rst_dv_count", 32'(dv_count), 32'd9);
    check("after_rst_byte",     32'(cap_byte), 32'h3C);
    check("after_rst_frm",      32'(cap_frm),  32'h0);
    check("after_rst_brk",      32'(cap_brk),  32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
